ucode_sequencer: RTL

//  Sequences micro-op expansion of multiply instructions. When fetch presents a MUL/MULS opcode, the block:
//   - stalls fetch and latches the operands into the ghost register file;
//   - walks a ghost PC through the external ucode ROM and issues each ROM word to decode as a micro-op;
//   - resolves the loop-closing BNE using execute feedback, then releases fetch.

---
 rtl/ucode_pkg.sv | 44 ++++
 rtl/ucode_sequencer_if.sv | 35 +++
 rtl/ucode_sequencer_opc_decode.sv | 26 ++
 rtl/ucode_sequencer.sv | 107 ++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// Shared definitions for the multiply micro-op sequencer: opcodes, FSM states
// and instruction field positions.
package ucode_pkg;

    localparam int UPC_W = 5;

    localparam logic [6:0] OPC_MUL_I  = 7'b0010000;
    localparam logic [6:0] OPC_MULS_I = 7'b0011000;
    localparam logic [6:0] OPC_MUL_R  = 7'b0110000;
    localparam logic [6:0] OPC_MULS_R = 7'b0111000;
    localparam logic [6:0] OPC_BNE    = 7'b1100001;

    // Field LSBs; rs2 and imm overlap on purpose (encoding picks one per opcode).
    localparam int OPC_LSB = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 17;
    localparam int RS2_LSB = 13;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        WAIT_BR,
        FINISH
    } state_t;

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
    } ghost_t;

    function automatic ghost_t unpack_fields(logic [31:0] w);
        ghost_t g;
        g.rd  = w[RD_LSB  +: 4];
        g.rs1 = w[RS1_LSB +: 4];
        g.rs2 = w[RS2_LSB +: 4];
        g.imm = w[IMM_LSB +: 16];
        return g;
    endfunction

endpackage

// File: rtl/ucode_sequencer_if.sv
// Fetch / ROM / decode / execute / ghost-regfile signals around the sequencer.
// master = sequencer side, slave = surrounding pipeline.
interface ucode_sequencer_if #(parameter int UPC_W = ucode_pkg::UPC_W);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             fetch_stall;
    logic [UPC_W-1:0] rom_addr;
    logic [31:0]      rom_data;
    logic             uop_valid;
    logic [31:0]      uop;
    logic             uop_ready;
    logic             br_resolved;
    logic             br_taken;
    logic             flush;
    logic             ghost_we;
    logic [15:0]      ghost_imm;
    logic [3:0]       ghost_rs1;
    logic [3:0]       ghost_rs2;
    logic [3:0]       ghost_rd;
    logic             set_flags;
    logic             busy;
    logic             iter_overflow;

    modport master (
        input  instr_valid, instr, rom_data, uop_ready, br_resolved, br_taken, flush,
        output fetch_stall, rom_addr, uop_valid, uop, ghost_we, ghost_imm,
               ghost_rs1, ghost_rs2, ghost_rd, set_flags, busy, iter_overflow
    );

    modport slave (
        output instr_valid, instr, rom_data, uop_ready, br_resolved, br_taken, flush,
        input  fetch_stall, rom_addr, uop_valid, uop, ghost_we, ghost_imm,
               ghost_rs1, ghost_rs2, ghost_rd, set_flags, busy, iter_overflow
    );
endinterface

// File: rtl/ucode_sequencer_opc_decode.sv
// Opcode classifier: fetch opcode -> multiply hit + slot select,
// micro-op opcode -> loop-closing branch flag.
module ucode_opc_decode
    import ucode_pkg::*;
(
    input  logic [6:0] opc,
    input  logic [6:0] uop_opc,
    output logic       hit,
    output logic [1:0] sel,
    output logic       is_bne
);

    always_comb begin
        hit = 1'b1;
        sel = 2'd0;
        case (opc)
            OPC_MUL_I:  sel = 2'd0;
            OPC_MULS_I: sel = 2'd1;
            OPC_MUL_R:  sel = 2'd2;
            OPC_MULS_R: sel = 2'd3;
            default:    hit = 1'b0;
        endcase
        is_bne = (uop_opc == OPC_BNE);
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Expands MUL/MULS instructions into ucode ROM micro-ops: stalls fetch, latches
// operands for the ghost regfile, walks the ghost PC and closes the loop on BNE.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int               UPC_W    = ucode_pkg::UPC_W,
    parameter int               SLOT_LG  = 3,
    parameter int               ITER_W   = 16,
    parameter logic [ITER_W-1:0] MAX_ITER = {ITER_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    ucode_sequencer_if.master bus
);

    state_t            state;
    logic [UPC_W-1:0]  ghost_pc;
    logic [UPC_W-1:0]  br_off;
    logic [ITER_W-1:0] iter_cnt;
    logic              muls_q;
    logic              iter_ovf_q;
    ghost_t            fields_q;

    logic       opc_hit;
    logic [1:0] opc_sel;
    logic       uop_is_bne;
    logic       mul_hit;
    logic       uop_valid_w;

    ucode_opc_decode u_dec (
        .opc     (bus.instr[OPC_LSB +: 7]),
        .uop_opc (bus.rom_data[OPC_LSB +: 7]),
        .hit     (opc_hit),
        .sel     (opc_sel),
        .is_bne  (uop_is_bne)
    );

    assign mul_hit     = bus.instr_valid & opc_hit & (state == IDLE);
    assign uop_valid_w = (state == ISSUE) & ~bus.flush;

    assign bus.fetch_stall   = mul_hit | (state != IDLE);
    assign bus.rom_addr      = ghost_pc;
    assign bus.uop_valid     = uop_valid_w;
    assign bus.uop           = uop_valid_w ? bus.rom_data : 32'd0;
    assign bus.ghost_we      = (state == LATCH) & ~bus.flush;
    assign bus.set_flags     = (state == FINISH) & muls_q & ~bus.flush;
    assign bus.busy          = (state != IDLE);
    assign bus.ghost_imm     = fields_q.imm;
    assign bus.ghost_rs1     = fields_q.rs1;
    assign bus.ghost_rs2     = fields_q.rs2;
    assign bus.ghost_rd      = fields_q.rd;
    assign bus.iter_overflow = iter_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ghost_pc   <= '0;
            br_off     <= '0;
            iter_cnt   <= '0;
            muls_q     <= 1'b0;
            iter_ovf_q <= 1'b0;
            fields_q   <= '0;
        end else if (bus.flush) begin
            // Abort drops the whole sequence context; overflow flag stays sticky.
            state    <= IDLE;
            ghost_pc <= '0;
            muls_q   <= 1'b0;
            fields_q <= '0;
        end else begin
            case (state)
                IDLE: if (mul_hit) begin
                    fields_q   <= unpack_fields(bus.instr);
                    muls_q     <= opc_sel[0];
                    ghost_pc   <= UPC_W'({opc_sel, {SLOT_LG{1'b0}}});
                    iter_cnt   <= '0;
                    iter_ovf_q <= 1'b0;
                    state      <= LATCH;
                end
                LATCH: state <= ISSUE;
                ISSUE: if (bus.uop_ready) begin
                    if (uop_is_bne) begin
                        // Keep the offset: the uop word is gone once we leave ISSUE.
                        br_off <= bus.rom_data[UPC_W-1:0];
                        state  <= WAIT_BR;
                    end else begin
                        ghost_pc <= ghost_pc + UPC_W'(1);
                    end
                end
                WAIT_BR: if (bus.br_resolved) begin
                    if (!bus.br_taken) begin
                        state <= FINISH;
                    end else if (iter_cnt < MAX_ITER) begin
                        ghost_pc <= ghost_pc + br_off;
                        iter_cnt <= iter_cnt + ITER_W'(1);
                        state    <= ISSUE;
                    end else begin
                        iter_ovf_q <= 1'b1;
                        state      <= FINISH;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
